// File: rtl/mult_pkg.sv
// Shared definitions for the iterative shift-add multiplier.
// Contents: operand width, step-counter width and the FSM state encoding.
package mult_pkg;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage : mult_pkg

// File: rtl/cla_adder_8bit.sv
// 8-bit carry-lookahead adder built from two 4-bit lookahead groups.
// Ports:
//   A, B  : 8-bit addends
//   Cin   : carry in
//   Sum   : 8-bit sum
//   Cout  : carry out of bit 7
module cla_adder_8bit (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Cin,
    output logic [7:0] Sum,
    output logic       Cout
);

    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;

    // Each group's carries depend only on its g/p and the group carry-in.
    always_comb begin
        g = A & B;
        p = A ^ B;
        c = '0;

        c[0] = Cin;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);

        c[5] = g[4] | (p[4] & c[4]);
        c[6] = g[5] | (p[5] & g[4]) | (p[5] & p[4] & c[4]);
        c[7] = g[6] | (p[6] & g[5]) | (p[6] & p[5] & g[4])
             | (p[6] & p[5] & p[4] & c[4]);
        c[8] = g[7] | (p[7] & g[6]) | (p[7] & p[6] & g[5])
             | (p[7] & p[6] & p[5] & g[4])
             | (p[7] & p[6] & p[5] & p[4] & c[4]);
    end

    assign Sum  = p ^ c[7:0];
    assign Cout = c[8];

endmodule : cla_adder_8bit

// File: rtl/shift_add_mult_ctrl.sv
// Iterative 8x8 unsigned multiplier: one shared CLA adder, eight add-and-shift
// steps, start/done handshake.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   start        : request, sampled only while idle
//   A, B         : multiplicand / multiplier, captured on the accepting edge
//   busy         : high from the accepting edge through the DONE cycle
//   done         : one-cycle completion pulse
//   product      : 16-bit result, held until the next completion
module shift_add_mult_ctrl
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned ZERO_BYPASS = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    state_e state_q, state_d;

    logic [WIDTH-1:0]   m_q,   m_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   q_q,   q_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] p_q,   p_d;

    logic [WIDTH-1:0]   add_b;
    logic [WIDTH-1:0]   sum;
    logic               cout;
    logic               zero_op;
    logic               last_step;

    assign add_b     = q_q[0] ? m_q : '0;
    assign zero_op   = (ZERO_BYPASS != 0) && ((A == '0) || (B == '0));
    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

    // Shared adder: ACC plus (multiplicand if current multiplier bit is set).
    cla_adder_8bit u_adder (
        .A    (acc_q),
        .B    (add_b),
        .Cin  (1'b0),
        .Sum  (sum),
        .Cout (cout)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        p_d     = p_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d   = A;
                    q_d   = B;
                    acc_d = '0;
                    cnt_d = '0;
                    if (zero_op) begin
                        p_d     = '0;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                // Right-shift {Cout, Sum, Q} by one; Sum[0] enters Q's MSB.
                acc_d = {cout, sum[WIDTH-1:1]};
                q_d   = {sum[0], q_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (last_step) begin
                    p_d     = {cout, sum[WIDTH-1:1], sum[0], q_q[WIDTH-1:1]};
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the state register only.
    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    assign product = p_q;

endmodule : shift_add_mult_ctrl

// File: tb/tb_shift_add_mult_ctrl.sv
// Directed self-checking bench for shift_add_mult_ctrl.
// dut uses zero bypass; dut_nb is the same block with the bypass disabled.
module tb_shift_add_mult_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        start_nb;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy,    done;
    logic [15:0] product;
    logic        busy_nb, done_nb;
    logic [15:0] product_nb;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_prod    = 16'h0000;
    logic [15:0] exp_prod_nb = 16'h0000;

    always #5 clk = ~clk;

    shift_add_mult_ctrl #(.WIDTH(8), .ZERO_BYPASS(1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .A       (a),
        .B       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    shift_add_mult_ctrl #(.WIDTH(8), .ZERO_BYPASS(0)) dut_nb (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start_nb),
        .A       (a),
        .B       (b),
        .busy    (busy_nb),
        .done    (done_nb),
        .product (product_nb)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transaction: start pulse, done expected 'lat' edges after the accept.
    task automatic do_mult(input string tag, input logic [7:0] ma, input logic [7:0] mb,
                           input logic [15:0] exp, input int lat, input bit nb);
        logic [15:0] prev;
        prev = nb ? exp_prod_nb : exp_prod;
        a = ma;
        b = mb;
        if (nb) start_nb = 1'b1;
        else    start    = 1'b1;
        tick(1);
        start    = 1'b0;
        start_nb = 1'b0;
        chk({tag, "_busy_e0"}, nb ? busy_nb : busy, 1'b1);
        chk({tag, "_done_e0"}, nb ? done_nb : done, (lat == 0) ? 1'b1 : 1'b0);
        chk({tag, "_prod_e0"}, nb ? product_nb : product, (lat == 0) ? exp : prev);
        for (int i = 1; i <= lat; i++) begin
            tick(1);
            if (i < lat) begin
                chk({tag, "_done_early"}, nb ? done_nb : done, 1'b0);
                chk({tag, "_prod_hold"}, nb ? product_nb : product, prev);
            end else begin
                chk({tag, "_done"}, nb ? done_nb : done, 1'b1);
                chk({tag, "_busy_done"}, nb ? busy_nb : busy, 1'b1);
                chk({tag, "_prod"}, nb ? product_nb : product, exp);
            end
        end
        tick(1);
        chk({tag, "_busy_idle"}, nb ? busy_nb : busy, 1'b0);
        chk({tag, "_done_idle"}, nb ? done_nb : done, 1'b0);
        chk({tag, "_prod_held"}, nb ? product_nb : product, exp);
        if (nb) exp_prod_nb = exp;
        else    exp_prod    = exp;
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        start_nb = 1'b0;
        a        = 8'h00;
        b        = 8'h00;

        // Reset state
        tick(2);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_prod", product, 16'h0000);
        chk("rst_prod_nb", product_nb, 16'h0000);
        reset_n = 1'b1;
        tick(2);
        chk("idle_busy", busy, 1'b0);

        // Full-scale and ordinary operands
        do_mult("ff_ff", 8'hFF, 8'hFF, 16'hFE01, 8, 1'b0);
        do_mult("0d_0b", 8'h0D, 8'h0B, 16'h008F, 8, 1'b0);
        do_mult("80_02", 8'h80, 8'h02, 16'h0100, 8, 1'b0);

        // Zero operand: bypass goes straight to DONE; without bypass it computes
        do_mult("zero_byp", 8'h00, 8'h5A, 16'h0000, 0, 1'b0);
        do_mult("zero_nb", 8'h00, 8'h5A, 16'h0000, 8, 1'b1);

        // start during CALC (before E3) and during DONE is ignored
        a     = 8'h12;
        b     = 8'h34;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            if (i == 3 || i == 9) begin
                a     = 8'hFF;
                b     = 8'hFF;
                start = 1'b1;
            end
            tick(1);
            start = 1'b0;
            chk("ign_done", done, (i == 8) ? 1'b1 : 1'b0);
            if (i == 8) chk("ign_prod", product, 16'h03A8);
            if (i == 9) chk("ign_busy_e9", busy, 1'b0);
        end
        tick(1);
        chk("ign_not_queued", busy, 1'b0);
        chk("ign_prod_held", product, 16'h03A8);
        exp_prod = 16'h03A8;

        // start held high: accepts every 10 cycles (E0, E10, E20)
        a     = 8'h07;
        b     = 8'h09;
        start = 1'b1;
        tick(1);
        for (int i = 1; i <= 29; i++) begin
            tick(1);
            chk("held_done", done, (i % 10 == 8) ? 1'b1 : 1'b0);
            chk("held_busy", busy, (i % 10 == 9) ? 1'b0 : 1'b1);
            chk("held_prod", product, (i < 8) ? 16'h03A8 : 16'h003F);
            if (i == 29) start = 1'b0;
        end
        tick(1);
        chk("held_stop", busy, 1'b0);
        exp_prod = 16'h003F;

        // Reset mid-CALC discards the operation
        a     = 8'hAA;
        b     = 8'h55;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(3);
        reset_n = 1'b0;
        tick(1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_prod", product, 16'h0000);
        chk("abort_prod_nb", product_nb, 16'h0000);
        reset_n     = 1'b1;
        exp_prod    = 16'h0000;
        exp_prod_nb = 16'h0000;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            chk("abort_no_done", done, 1'b0);
        end
        do_mult("03_05", 8'h03, 8'h05, 16'h000F, 8, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_shift_add_mult_ctrl
